// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Accumulator-based sequencer in front of the AU (add/sub) and LU (logic)
//   datapath. One operation is accepted at a time over a Start/Busy/Done
//   handshake. The operation combines the 8-bit accumulator with a latched
//   operand. The result is written back to the accumulator together with
//   Zero/Negative/Carry/Overflow flags.
//
//   Optional feature macro: ALU_SEQUENCER_MUL_EN
//     defined     -> opcode 9 is an unsigned 8x8 shift-add multiply
//                    (8 iterations, 16-bit product, low byte to Acc)
//     not defined -> no multiply logic is built; opcode 9 is illegal
//
// Ports
//   i_clock       system clock, rising-edge active
//   i_reset       asynchronous active-high reset
//   i_start       request, sampled only while idle
//   i_opcode      operation select, latched at accept
//   i_operand     B operand, latched at accept
//   o_acc         accumulator (A operand and result)
//   o_busy        high whenever the sequencer is not idle
//   o_done        one-cycle completion pulse
//   o_zero        result == 0x00
//   o_negative    result bit 7
//   o_carry_flag  carry-out (ADD/INC), borrow (SUB/DEC), high byte != 0 (MUL)
//   o_overflow    signed overflow (MUL: high byte != 0)
//   o_error       last completed opcode was illegal
// ---------------------------------------------------------------------------
module alu_sequencer (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_opcode,
  input  logic [7:0] i_operand,
  output logic [7:0] o_acc,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_zero,
  output logic       o_negative,
  output logic       o_carry_flag,
  output logic       o_overflow,
  output logic       o_error
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_opcode;
  logic [7:0] r_operand;
  logic [7:0] r_acc;
  logic       r_zero, r_negative, r_carry, r_overflow, r_error;
  logic       r_busy, r_done;

  // Result write-back controls
  logic       w_write;
  logic       w_illegal;
  logic [7:0] w_res;
  logic       w_res_c, w_res_v;

  // AU: Control 00 ADD, 01 INC, 10 SUB, 11 DEC
  logic [1:0] w_au_ctrl;
  logic [7:0] w_au_b;
  logic [8:0] w_au_sum;
  logic       w_au_v;
  // LU: Control 00 AND, 01 OR, 10 XOR, 11 NOT(A)
  logic [1:0] w_lu_ctrl;
  logic [7:0] w_lu_res;

  wire w_accept = (r_state == S_IDLE) && i_start;

  assign w_au_ctrl = 2'(r_opcode - 4'd1);
  assign w_lu_ctrl = 2'(r_opcode - 4'd5);
  assign w_au_b    = w_au_ctrl[0] ? 8'h01 : r_operand;
  // 9-bit subtraction leaves the borrow (inverted AU carry) in bit 8.
  assign w_au_sum  = w_au_ctrl[1] ? ({1'b0, r_acc} - {1'b0, w_au_b})
                                  : ({1'b0, r_acc} + {1'b0, w_au_b});
  assign w_au_v    = w_au_ctrl[1]
                   ? ((r_acc[7] != w_au_b[7]) && (w_au_sum[7] != r_acc[7]))
                   : ((r_acc[7] == w_au_b[7]) && (w_au_sum[7] != r_acc[7]));

  always_comb begin
    w_lu_res = r_acc & r_operand;
    case (w_lu_ctrl)
      2'b00:   w_lu_res = r_acc & r_operand;
      2'b01:   w_lu_res = r_acc | r_operand;
      2'b10:   w_lu_res = r_acc ^ r_operand;
      default: w_lu_res = ~r_acc;
    endcase
  end

`ifdef ALU_SEQUENCER_MUL_EN
  logic [2:0]  r_cnt;
  logic [15:0] r_prod;
  logic [15:0] w_prod_next;

  // One shift-add step per cycle; bit r_cnt of the multiplier selects
  // whether the shifted multiplicand is accumulated.
  assign w_prod_next = r_prod + (r_operand[r_cnt] ? ({8'h00, r_acc} << r_cnt) : 16'h0000);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= 3'd0;
      r_prod <= 16'h0000;
    end else if (w_accept) begin
      r_cnt  <= 3'd0;
      r_prod <= 16'h0000;
    end else if (r_state == S_MUL) begin
      r_cnt  <= r_cnt + 3'd1;
      r_prod <= w_prod_next;
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_illegal    = 1'b0;
    w_res        = r_acc;
    w_res_c      = 1'b0;
    w_res_v      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_EXEC;
`ifdef ALU_SEQUENCER_MUL_EN
          if (i_opcode == 4'd9) w_state_next = S_MUL;
`endif
        end
      end
      S_EXEC: begin
        w_state_next = S_DONE;
        w_write      = 1'b1;
        if (r_opcode == 4'd0) begin
          w_res = r_operand;
        end else if (r_opcode <= 4'd4) begin
          w_res   = w_au_sum[7:0];
          w_res_c = w_au_sum[8];
          w_res_v = w_au_v;
        end else if (r_opcode <= 4'd8) begin
          w_res = w_lu_res;
        end else begin
          // Illegal (including opcode 9 without the multiplier): no write-back.
          w_write   = 1'b0;
          w_illegal = 1'b1;
        end
      end
`ifdef ALU_SEQUENCER_MUL_EN
      S_MUL: begin
        if (r_cnt == 3'd7) begin
          w_state_next = S_DONE;
          w_write      = 1'b1;
          w_res        = w_prod_next[7:0];
          w_res_c      = |w_prod_next[15:8];
          w_res_v      = |w_prod_next[15:8];
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_opcode   <= 4'd0;
      r_operand  <= 8'h00;
      r_acc      <= 8'h00;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Busy/Done are registered from the next state so they line up with it.
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_opcode  <= i_opcode;
        r_operand <= i_operand;
      end
      if (w_write) begin
        r_acc      <= w_res;
        r_zero     <= (w_res == 8'h00);
        r_negative <= w_res[7];
        r_carry    <= w_res_c;
        r_overflow <= w_res_v;
        r_error    <= 1'b0;
      end else if (w_illegal) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_acc        = r_acc;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_zero       = r_zero;
  assign o_negative   = r_negative;
  assign o_carry_flag = r_carry;
  assign o_overflow   = r_overflow;
  assign o_error      = r_error;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [7:0] operand = 8'h00;
  logic [7:0] o_acc;
  logic       o_busy, o_done, o_zero, o_negative, o_carry_flag, o_overflow, o_error;

  alu_sequencer dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_opcode     (opcode),
    .i_operand    (operand),
    .o_acc        (o_acc),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_zero       (o_zero),
    .o_negative   (o_negative),
    .o_carry_flag (o_carry_flag),
    .o_overflow   (o_overflow),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

`ifdef ALU_SEQUENCER_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    int op;
    int b;
    int acc;
    bit z, n, c, v, e;
    int done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_issued = 0;
  int   n_done_seen = 0;

  // Reference model state
  int m_acc = 0;
  bit m_z = 0, m_n = 0, m_c = 0, m_v = 0, m_e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Behavioural model: plain integer arithmetic on the opcode rules.
  task automatic model(input int op, input int b, output exp_t e, output int lat);
    int a, r, bb, s;
    bit legal, c, v;
    a = m_acc; r = 0; c = 0; v = 0; legal = 1; lat = 1;
    case (op)
      0: r = b;
      1, 2: begin
        bb = (op == 2) ? 1 : b;
        r = (a + bb) % 256;
        c = (a + bb) > 255;
        s = sgn(a) + sgn(bb);
        v = (s > 127) || (s < -128);
      end
      3, 4: begin
        bb = (op == 4) ? 1 : b;
        r = (a - bb + 256) % 256;
        c = a < bb;
        s = sgn(a) - sgn(bb);
        v = (s > 127) || (s < -128);
      end
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = 255 - a;
      9: begin
        if (MUL_EN) begin
          r = (a * b) % 256;
          c = (a * b) > 255;
          v = c;
          lat = 8;
        end else legal = 0;
      end
      default: legal = 0;
    endcase
    if (legal) begin
      m_acc = r; m_z = (r == 0); m_n = (r >= 128); m_c = c; m_v = v; m_e = 0;
    end else begin
      m_e = 1;
    end
    e.op = op; e.b = b; e.acc = m_acc;
    e.z = m_z; e.n = m_n; e.c = m_c; e.v = m_v; e.e = m_e;
    e.done_cyc = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (o_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (o_busy) check("idle_timeout", int'(o_busy), 0);
  endtask

  // Issue one operation; optionally poke Start with another opcode while busy.
  task automatic issue(input int op, input int b, input bit poke);
    exp_t e;
    int lat;
    wait_idle();
    start = 1'b1;
    opcode = 4'(op);
    operand = 8'(b);
    model(op, b, e, lat);
    e.done_cyc = cyc + 1 + lat;
    sb_q.push_back(e);
    n_issued++;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", int'(o_busy), 1);
    if (poke) begin
      @(negedge clk);
      start = 1'b1;
      opcode = 4'((op + 5) % 9);
      operand = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc"}, int'(o_acc), 0);
    check({tag, "_busy"}, int'(o_busy), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_flags"}, int'({o_zero, o_negative, o_carry_flag, o_overflow, o_error}), 0);
  endtask

  // Monitor: pops the scoreboard whenever Done is presented.
  always @(negedge clk) begin
    if (!rst && o_done) begin
      n_done_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("op=%0d b=0x%02h -> acc=0x%02h z=%0d n=%0d c=%0d v=%0d err=%0d done@%0d",
                 e.op, e.b, o_acc, o_zero, o_negative, o_carry_flag, o_overflow, o_error, cyc);
        check("acc", int'(o_acc), e.acc);
        check("zero", int'(o_zero), int'(e.z));
        check("negative", int'(o_negative), int'(e.n));
        check("carry", int'(o_carry_flag), int'(e.c));
        check("overflow", int'(o_overflow), int'(e.v));
        check("error", int'(o_error), int'(e.e));
        check("done_latency", cyc, e.done_cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_active");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_state");

    // Directed sequences
    issue(0, 8'h7F, 0); issue(1, 8'h01, 0);
    issue(0, 8'h00, 0); issue(4, 8'h5A, 0);
    issue(0, 8'h80, 0); issue(3, 8'h01, 0);
    issue(0, 8'hF0, 0); issue(7, 8'hFF, 0); issue(8, 8'h33, 0);
    issue(0, 8'h0F, 0); issue(9, 8'h11, 0);
    issue(0, 8'h10, 0); issue(9, 8'h10, 0);
    issue(0, 8'h33, 1);
    issue(15, 8'hAA, 0);
    issue(0, 8'h05, 0);
    issue(1, 8'hFF, 0);
    issue(10, 8'h01, 0);

    // Reset mid-operation (MUL iteration 4 when built, else inside EXEC)
    wait_idle();
    start = 1'b1;
    opcode = 4'd9;
    operand = 8'hFF;
    @(posedge clk);
    if (MUL_EN) repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    start = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_e = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_reset", n_done_seen, n_issued - sb_q.size());
    issue(0, 8'h05, 0);

    // Randomized operations
    for (int i = 0; i < 80; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    t = 0;
    while (sb_q.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    check("done_count", n_done_seen, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
